// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read, one-entry output
// register toward decode, and branch redirects that squash in-flight words.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        InstrReady
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state,    w_state_nxt;
    logic [31:0] r_pc,       w_pc_nxt;
    logic [31:0] r_pend,     w_pend_nxt;
    logic [31:0] r_instr,    w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_valid,    w_valid_nxt;
    logic        w_req;
    logic [31:0] w_target;

    assign w_target = {BranchTarget[31:2], 2'b00};

    // NOTE: every signal gets its hold value before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_nxt     = r_pend;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_req          = 1'b0;
        unique case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (ImemAck) begin
                    if (Branch) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_instr_nxt    = ImemData;
                        w_instr_pc_nxt = r_pc;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = HOLD;
                    end
                end else if (Branch) begin
                    w_pend_nxt  = w_target;
                    w_state_nxt = DROP;
                end
            end
            HOLD: begin
                // A redirect also retires the held word, whether or not decode took it.
                if (Branch) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = FETCH;
                end else if (InstrReady) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = FETCH;
                end
            end
            DROP: begin
                w_req = 1'b1;
                if (ImemAck) begin
                    w_pc_nxt    = Branch ? w_target : r_pend;
                    w_state_nxt = FETCH;
                end else if (Branch) begin
                    w_pend_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC_ALIGNED;
            r_pend     <= 32'd0;
            r_instr    <= 32'd0;
            r_instr_pc <= 32'd0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign ImemReq    = w_req & ~rst;
    assign ImemAddr   = r_pc;
    assign InstrValid = r_valid;
    assign Instr      = r_instr;
    assign InstrPC    = r_instr_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle vectors with hand-derived
// expected outputs, passed through a scoreboard queue before comparison.
module tb_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] bt;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_ipc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Branch = 1'b0;
    logic [31:0] BranchTarget = 32'd0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemData = 32'd0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrReady = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    fetch_ctrl #(.RESET_PC(32'h00000000)) dut (
        .clk          (clk),
        .rst          (rst),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemData     (ImemData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic b, logic [31:0] t, logic a, logic [31:0] d,
                                logic y, logic er, logic [31:0] ea, logic ev,
                                logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.rst = r; v.br = b; v.bt = t; v.ack = a; v.data = d; v.rdy = y;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_instr = ei; v.exp_ipc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expectations, then compare before the next edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst = v.rst; Branch = v.br; BranchTarget = v.bt;
        ImemAck = v.ack; ImemData = v.data; InstrReady = v.rdy;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        check({tag, ".req"}, {31'd0, ImemReq}, {31'd0, e.exp_req});
        check({tag, ".valid"}, {31'd0, InstrValid}, {31'd0, e.exp_valid});
        if (e.exp_req) check({tag, ".addr"}, ImemAddr, e.exp_addr);
        if (e.exp_valid) begin
            check({tag, ".instr"}, Instr, e.exp_instr);
            check({tag, ".ipc"}, InstrPC, e.exp_ipc);
        end
    endtask

    initial begin
        //            rst br bt            ack data          rdy req addr          v  instr         ipc
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h20080005, 1, 1, 32'h0,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h20080005, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h4,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h4,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h4,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 1, 32'h4,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'hDEADBEEF, 32'h4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'hDEADBEEF, 32'h4));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hDEADBEEF, 32'h4));
        vecs.push_back(mk(0, 1, 32'h40,       0, 32'h0,        0, 1, 32'h8,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hBAD0BAD0, 1, 1, 32'h8,        0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h40,       0, 32'h0,        32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) begin
                check("reset.instr", Instr, 32'h0);
                check("reset.ipc", InstrPC, 32'h0);
            end
        end

        // Redirect into DROP, then two newer redirects; the last target must win.
        step(mk(0, 1, 32'h50,       0, 32'h0,        0, 1, 32'h40, 0, 32'h0, 32'h0), "drop0");
        step(mk(0, 1, 32'h80,       0, 32'h0,        0, 1, 32'h40, 0, 32'h0, 32'h0), "drop1");
        step(mk(0, 1, 32'hC0,       0, 32'h0,        0, 1, 32'h40, 0, 32'h0, 32'h0), "drop2");
        step(mk(0, 0, 32'h0,        1, 32'hBAD1BAD1, 0, 1, 32'h40, 0, 32'h0, 32'h0), "drop_ack");
        // Branch coinciding with ack in FETCH discards the word and refetches at the target.
        step(mk(0, 1, 32'h10,       1, 32'hBAD2BAD2, 0, 1, 32'hC0, 0, 32'h0, 32'h0), "br_ack");
        step(mk(0, 0, 32'h0,        1, 32'h11111111, 0, 1, 32'h10, 0, 32'h0, 32'h0), "fetch10");
        // Branch with InstrReady in HOLD; target low bits are forced to zero.
        step(mk(0, 1, 32'h23,       0, 32'h0,        1, 0, 32'h0,  1, 32'h11111111, 32'h10), "hold_br");
        step(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h20, 0, 32'h0, 32'h0), "after_br");
        // Reach PC=FFFFFFFC and check the increment wraps to zero.
        step(mk(0, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 1, 32'h20, 0, 32'h0, 32'h0), "wrap_br");
        step(mk(0, 0, 32'h0,        1, 32'h0,        0, 1, 32'h20, 0, 32'h0, 32'h0), "wrap_drop");
        step(mk(0, 0, 32'h0,        1, 32'h22222222, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0), "wrap_fetch");
        step(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,  1, 32'h22222222, 32'hFFFFFFFC), "wrap_hold");
        step(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,  0, 32'h0, 32'h0), "wrap_next");
        // Reset in the middle of DROP overrides branch, ack and ready.
        step(mk(0, 1, 32'h200,      0, 32'h0,        0, 1, 32'h0,  0, 32'h0, 32'h0), "rd_enter");
        step(mk(1, 1, 32'h300,      1, 32'h33333333, 1, 0, 32'h0,  0, 32'h0, 32'h0), "rd_rst");
        step(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,  0, 32'h0, 32'h0), "rd_after");
        step(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,  0, 32'h0, 32'h0), "rd_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
